// File: rtl/sdram_ch2_word_adapter_if.sv
// Client word-request port plus the level-held rd/wr port of SDRAM channel 2.
// The adapter sits on the slave side; the client and controller model sit on the master side.
interface sdram_ch2_word_adapter_if;
  logic        req;
  logic        we;
  logic [19:0] addr;
  logic [31:0] din;
  logic [3:0]  be;
  logic [31:0] dout;
  logic        ack;
  logic        busy;
  logic [20:0] ch2addr;
  logic [15:0] ch2din;
  logic [1:0]  ch2wr;
  logic        ch2rd;
  logic [15:0] ch2dout;
  logic        ch2rdy;

  modport master (
    output req, we, addr, din, be, ch2dout, ch2rdy,
    input  dout, ack, busy, ch2addr, ch2din, ch2wr, ch2rd
  );

  modport slave (
    input  req, we, addr, din, be, ch2dout, ch2rdy,
    output dout, ack, busy, ch2addr, ch2din, ch2wr, ch2rd
  );
endinterface

// File: rtl/sdram_ch2_word_adapter.sv
// Splits 32-bit big-endian word requests into up to two 16-bit ch2 accesses
// using the controller's level-held strobe / ch2rdy handshake.
module sdram_ch2_word_adapter #(
  parameter int RELEASE_CYCLES = 2,
  parameter int LO_WAIT_MAX    = 8
) (
  input logic clk,
  input logic rst_n,
  sdram_ch2_word_adapter_if.slave bus
);

  localparam int CNT_MAX = (LO_WAIT_MAX > RELEASE_CYCLES) ? LO_WAIT_MAX : RELEASE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LO_LAST  = CW'(LO_WAIT_MAX - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, RELEASE, DONE} state_t;

  state_t        state, state_nx;
  logic          we_q, we_nx;
  logic [19:0]   addr_q, addr_nx;
  logic [31:0]   din_q, din_nx;
  logic [3:0]    be_q, be_nx;
  logic          half_lo, half_lo_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   dout_q, dout_nx;
  logic          ack_q, ack_nx;
  logic          busy_q, busy_nx;
  logic          rd_q, rd_nx;
  logic [1:0]    wr_q, wr_nx;
  logic [20:0]   caddr_q, caddr_nx;
  logic [15:0]   cdin_q, cdin_nx;

  always_comb begin
    state_nx   = state;
    we_nx      = we_q;
    addr_nx    = addr_q;
    din_nx     = din_q;
    be_nx      = be_q;
    half_lo_nx = half_lo;
    cnt_nx     = cnt;
    dout_nx    = dout_q;
    ack_nx     = 1'b0;
    busy_nx    = busy_q;
    rd_nx      = rd_q;
    wr_nx      = wr_q;
    caddr_nx   = caddr_q;
    cdin_nx    = cdin_q;

    case (state)
      IDLE: begin
        if (bus.req) begin
          we_nx   = bus.we;
          addr_nx = bus.addr;
          din_nx  = bus.din;
          be_nx   = (!bus.we && bus.be == 4'h0) ? 4'hF : bus.be;
          busy_nx = 1'b1;
          if (bus.we && bus.be == 4'h0) begin
            state_nx = DONE;
            ack_nx   = 1'b1;
          end else begin
            // The HI half goes first unless its enables are empty.
            half_lo_nx = (be_nx[3:2] == 2'b00);
            state_nx   = ISSUE;
            caddr_nx   = {bus.addr, half_lo_nx};
            cdin_nx    = half_lo_nx ? bus.din[15:0] : bus.din[31:16];
            rd_nx      = !bus.we;
            wr_nx      = !bus.we ? 2'b00 : (half_lo_nx ? be_nx[1:0] : be_nx[3:2]);
          end
        end
      end

      ISSUE: begin
        state_nx = WAIT_LO;
        cnt_nx   = '0;
      end

      WAIT_LO: begin
        // A controller that never drops ch2rdy is assumed to have already finished.
        if (!bus.ch2rdy || cnt == LO_LAST) begin
          state_nx = WAIT_HI;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      WAIT_HI: begin
        if (bus.ch2rdy) begin
          if (!we_q) begin
            if (half_lo) dout_nx[15:0]  = bus.ch2dout;
            else         dout_nx[31:16] = bus.ch2dout;
          end
          rd_nx    = 1'b0;
          wr_nx    = 2'b00;
          cnt_nx   = '0;
          state_nx = RELEASE;
        end
      end

      RELEASE: begin
        if (cnt == REL_LAST) begin
          if (!half_lo && be_q[1:0] != 2'b00) begin
            half_lo_nx = 1'b1;
            state_nx   = ISSUE;
            caddr_nx   = {addr_q, 1'b1};
            cdin_nx    = din_q[15:0];
            rd_nx      = !we_q;
            wr_nx      = we_q ? be_q[1:0] : 2'b00;
          end else begin
            state_nx = DONE;
            ack_nx   = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      DONE: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= '0;
      half_lo <= 1'b0;
      cnt     <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 2'b00;
      caddr_q <= '0;
      cdin_q  <= '0;
    end else begin
      state   <= state_nx;
      we_q    <= we_nx;
      addr_q  <= addr_nx;
      din_q   <= din_nx;
      be_q    <= be_nx;
      half_lo <= half_lo_nx;
      cnt     <= cnt_nx;
      dout_q  <= dout_nx;
      ack_q   <= ack_nx;
      busy_q  <= busy_nx;
      rd_q    <= rd_nx;
      wr_q    <= wr_nx;
      caddr_q <= caddr_nx;
      cdin_q  <= cdin_nx;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.ch2rd   = rd_q;
  assign bus.ch2wr   = wr_q;
  assign bus.ch2addr = caddr_q;
  assign bus.ch2din  = cdin_q;

endmodule

// File: tb/tb_sdram_ch2_word_adapter.sv
// Bench for sdram_ch2_word_adapter: SDRAM ch2 controller model with random slot latency,
// word-level reference memory, and a strobe monitor for gap/stability/exclusivity.
module tb_sdram_ch2_word_adapter;
  localparam int RELEASE_CYCLES = 2;
  localparam int LO_WAIT_MAX    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_ch2_word_adapter_if bus();

  sdram_ch2_word_adapter #(
    .RELEASE_CYCLES(RELEASE_CYCLES),
    .LO_WAIT_MAX(LO_WAIT_MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        rd;
    logic [1:0]  wr;
    logic [20:0] addr;
    logic [15:0] din;
  } acc_t;

  function automatic logic [15:0] init_half(int i);
    if (i == 32) return 16'h1234;
    if (i == 33) return 16'h5678;
    return 16'(i * 40503 + 7);
  endfunction

  // Controller model: 64 half-words, random slot delay, optional stuck-ready mode.
  logic [15:0] mem [64];
  logic        mem_ready = 1'b0;
  logic        stuck = 1'b0;
  logic        rdy_r = 1'b1;
  logic [15:0] cdout_r = 16'h0;
  int          cphase = 0;
  int          cdly = 0;
  int          clow = 0;
  logic        act;

  assign act         = bus.ch2rd | (|bus.ch2wr);
  assign bus.ch2rdy  = rdy_r;
  assign bus.ch2dout = cdout_r;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_half(i);
      mem_ready <= 1'b1;
    end else begin
      cdout_r <= mem[bus.ch2addr[5:0]];
      case (cphase)
        0: if (act) begin
          if (bus.ch2wr[1]) mem[bus.ch2addr[5:0]][15:8] <= bus.ch2din[15:8];
          if (bus.ch2wr[0]) mem[bus.ch2addr[5:0]][7:0]  <= bus.ch2din[7:0];
          if (stuck) cphase <= 3;
          else begin
            cdly   <= int'($urandom_range(0, 3));
            cphase <= 1;
          end
        end
        1: if (cdly == 0) begin
          rdy_r  <= 1'b0;
          clow   <= int'($urandom_range(1, 4));
          cphase <= 2;
        end else cdly <= cdly - 1;
        2: if (clow == 0) begin
          rdy_r  <= 1'b1;
          cphase <= 3;
        end else clow <= clow - 1;
        default: if (!act) cphase <= 0;
      endcase
    end
  end

  // Monitor: records each strobe assertion and the rule violations seen on the ch2 side.
  acc_t acc_q[$];
  acc_t obs_acc;
  acc_t cur_acc = '0;
  logic prev_act = 1'b0;
  int   low_cnt = 100;
  int   cur_len = 0;
  int   last_len = 0;
  int   viol_gap = 0;
  int   viol_both = 0;
  int   viol_stab = 0;

  assign obs_acc = {bus.ch2rd, bus.ch2wr, bus.ch2addr, (bus.ch2rd ? 16'h0 : bus.ch2din)};

  always @(posedge clk) begin
    if (bus.ch2rd && (|bus.ch2wr)) viol_both <= viol_both + 1;
    if (act && !prev_act) begin
      if (low_cnt < RELEASE_CYCLES) viol_gap <= viol_gap + 1;
      acc_q.push_back(obs_acc);
      cur_acc <= obs_acc;
      cur_len <= 1;
    end else if (act) begin
      if (obs_acc != cur_acc) viol_stab <= viol_stab + 1;
      cur_len <= cur_len + 1;
    end
    if (!act && prev_act) last_len <= cur_len;
    low_cnt  <= !rst_n ? 100 : (act ? 0 : low_cnt + 1);
    prev_act <= act;
  end

  // Reference model state: whole words, plus the dout the client should see.
  logic [31:0] ref_mem [32];
  logic [31:0] dout_ref = 32'h0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Predicts the half accesses, memory update and dout of one word request.
  task automatic predict(input logic w, input logic [19:0] a, input logic [31:0] d,
                         input logic [3:0] b, output acc_t exp_q[$]);
    logic [3:0]  eb;
    logic [31:0] word;
    acc_t        e;
    exp_q.delete();
    eb = (!w && b == 4'h0) ? 4'hF : b;
    word = ref_mem[a[4:0]];
    for (int h = 0; h < 2; h++) begin
      if ((h == 0 ? eb[3:2] : eb[1:0]) != 2'b00) begin
        e.rd   = !w;
        e.wr   = w ? (h == 0 ? eb[3:2] : eb[1:0]) : 2'b00;
        e.addr = {a, h[0]};
        e.din  = w ? (h == 0 ? d[31:16] : d[15:0]) : 16'h0;
        exp_q.push_back(e);
      end
    end
    if (w) begin
      for (int j = 0; j < 4; j++) if (eb[j]) word[j*8 +: 8] = d[j*8 +: 8];
      ref_mem[a[4:0]] = word;
    end else begin
      if (eb[3:2] != 2'b00) dout_ref[31:16] = word[31:16];
      if (eb[1:0] != 2'b00) dout_ref[15:0]  = word[15:0];
    end
  endtask

  task automatic apply_stimulus(input logic w, input logic [19:0] a, input logic [31:0] d,
                                input logic [3:0] b, output int lat);
    acc_t exp_q[$];
    int   n;
    predict(w, a, d, b, exp_q);
    acc_q.delete();
    bus.req  = 1'b1;
    bus.we   = w;
    bus.addr = a;
    bus.din  = d;
    bus.be   = b;
    step();
    bus.req = 1'b0;
    check_output("busy_after_accept", bus.busy, 1);
    lat = 0;
    while (!bus.ack && lat < 300) begin
      step();
      lat++;
    end
    check_output("ack_seen", bus.ack, 1);
    check_output("dout", bus.dout, dout_ref);
    check_output("n_access", acc_q.size(), exp_q.size());
    n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_output("access", acc_q[i], exp_q[i]);
    step();
    check_output("ack_single", bus.ack, 0);
    check_output("busy_drop", bus.busy, 0);
  endtask

  initial begin
    int   lat;
    int   cyc;
    int   nacc;
    acc_t exp_q[$];

    bus.req  = 1'b0;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.din  = '0;
    bus.be   = '0;
    for (int k = 0; k < 32; k++) ref_mem[k] = {init_half(2 * k), init_half(2 * k + 1)};
    repeat (3) step();

    check_output("rst_dout", bus.dout, 0);
    check_output("rst_ack", bus.ack, 0);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_ch2rd", bus.ch2rd, 0);
    check_output("rst_ch2wr", bus.ch2wr, 0);
    check_output("rst_ch2addr", bus.ch2addr, 0);
    check_output("rst_ch2din", bus.ch2din, 0);
    rst_n = 1'b1;
    step();

    $display("[TB] directed: full read, partial writes, empty-enable cases");
    apply_stimulus(1'b0, 20'h00010, 32'h0, 4'hF, lat);
    check_output("read_12345678", bus.dout, 32'h12345678);
    apply_stimulus(1'b1, 20'h00003, 32'hAABBCCDD, 4'b0011, lat);
    apply_stimulus(1'b1, 20'h00005, 32'h11223344, 4'b1000, lat);
    apply_stimulus(1'b0, 20'h00005, 32'h0, 4'hF, lat);
    apply_stimulus(1'b1, 20'h00007, 32'hDEADBEEF, 4'h0, lat);
    check_output("wr_be0_latency", lat, 0);
    apply_stimulus(1'b0, 20'h00003, 32'h0, 4'h0, lat);
    apply_stimulus(1'b0, 20'h00006, 32'h0, 4'b0010, lat);

    $display("[TB] controller never lowers ch2rdy");
    stuck = 1'b1;
    apply_stimulus(1'b0, 20'h00009, 32'h0, 4'hF, lat);
    check_output("timeout_strobe_len", last_len, 1 + LO_WAIT_MAX + 1);
    stuck = 1'b0;
    repeat (2) step();

    $display("[TB] reset during WAIT_HI of the HI half");
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 20'h00011;
    bus.be   = 4'hF;
    step();
    bus.req = 1'b0;
    cyc = 0;
    while (!(bus.ch2rd && !bus.ch2rdy && !bus.ch2addr[0]) && cyc < 50) begin
      step();
      cyc++;
    end
    check_output("reach_wait_hi", (bus.ch2rd && !bus.ch2rdy && !bus.ch2addr[0]), 1);
    step();
    rst_n = 1'b0;
    #1;
    check_output("rstmid_ch2rd", bus.ch2rd, 0);
    check_output("rstmid_busy", bus.busy, 0);
    check_output("rstmid_ack", bus.ack, 0);
    check_output("rstmid_dout", bus.dout, 0);
    dout_ref = 32'h0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) step();
    apply_stimulus(1'b0, 20'h00011, 32'h0, 4'hF, lat);

    $display("[TB] back-to-back reads with req held");
    predict(1'b0, 20'h00012, 32'h0, 4'hF, exp_q);
    nacc = 2 * exp_q.size();
    acc_q.delete();
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 20'h00012;
    bus.be   = 4'hF;
    cyc = 0;
    while (!bus.ack && cyc < 300) begin step(); cyc++; end
    check_output("b2b_ack1", bus.ack, 1);
    check_output("b2b_dout1", bus.dout, dout_ref);
    cyc = 0;
    while (bus.busy && cyc < 10) begin step(); cyc++; end
    check_output("b2b_busy_low", bus.busy, 0);
    cyc = 0;
    while (!bus.busy && cyc < 10) begin step(); cyc++; end
    check_output("b2b_idle_cycles", cyc, 1);
    bus.req = 1'b0;
    cyc = 0;
    while (!bus.ack && cyc < 300) begin step(); cyc++; end
    check_output("b2b_ack2", bus.ack, 1);
    check_output("b2b_dout2", bus.dout, dout_ref);
    check_output("b2b_n_access", acc_q.size(), nacc);
    step();

    $display("[TB] random word requests");
    for (int t = 0; t < 40; t++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 20'($urandom_range(0, 31)), $urandom,
                     4'($urandom_range(0, 15)), lat);
      if ($urandom_range(0, 1) == 1) step();
    end

    check_output("strobe_gap", viol_gap, 0);
    check_output("rd_wr_exclusive", viol_both, 0);
    check_output("addr_din_stable", viol_stab, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_ch2_word_adapter.md
Name: sdram_ch2_word_adapter

Overview:
- Upstream front-end for the SDRAM controller's secondary 16-bit channel (ch2).
- Accepts 32-bit word requests from a CPU/DMA client and splits each into at most two 16-bit ch2 accesses. Halves with zero byte enables are skipped.
- Speaks the controller's level-held rd/wr protocol: pulse on ch2rdy, release gap between accesses.
- Returns one assembled 32-bit result with a single-cycle ack. Word layout is big-endian.

Parameters:
- RELEASE_CYCLES, 2: cycles ch2rd/ch2wr are held low between consecutive ch2 accesses (controller lock release). Minimum 2.
- LO_WAIT_MAX, 8: cycles allowed for ch2rdy to fall after a strobe. If it has not fallen by then, the access is treated as already complete.

Ports:
- clk, in, 1: system clock, same clock as the SDRAM controller.
- rst_n, in, 1: asynchronous active-low reset.
- req, in, 1: request strobe. Sampled only while busy=0.
- we, in, 1: 1=write, 0=read.
- addr, in, 20: word address [21:2].
- din, in, 32: write data. [31:16] goes to the even half-word, [15:0] to the odd half-word.
- be, in, 4: byte enables. be[3:2] covers the high half, be[1:0] the low half.
- dout, out, 32: read data, valid when ack=1 and held until the next ack.
- ack, out, 1: single-cycle completion pulse.
- busy, out, 1: high from the cycle after an accepted req until the cycle after ack.
- ch2addr, out, 21: half-word address to the controller.
- ch2din, out, 16: half-word write data.
- ch2wr, out, 2: byte write strobes, level-held.
- ch2rd, out, 1: read strobe, level-held.
- ch2dout, in, 16: controller read data.
- ch2rdy, in, 1: controller ready. Low while an access is pending.

Behaviour:
- Reset values: dout=0, ack=0, busy=0, ch2rd=0, ch2wr=0, ch2addr=0, ch2din=0, FSM=IDLE.
- Reset asserted mid-operation aborts immediately and drops the strobes. The in-flight SDRAM access may still complete; its result is discarded.
- Accept: in IDLE, req=1 latches we/addr/din/be and sets busy.
  - Read with be=0 is treated as be=4'hF.
  - Write with be=0 completes with ack after 1 cycle and issues no ch2 access.
- Half list:
  - HI half: {addr,1'b0}, data din[31:16], enables be[3:2].
  - LO half: {addr,1'b1}, data din[15:0], enables be[1:0].
  - A half is issued only if its enable pair is nonzero. Reads issue every enabled half.
  - HI is always issued before LO.
- FSM states: IDLE → ISSUE → WAIT_LO → WAIT_HI → RELEASE → (ISSUE for the next half | DONE) → IDLE.
- ISSUE:
  - Drive ch2addr/ch2din.
  - Reads: ch2rd=1.
  - Writes: ch2wr=the half's enable pair.
  - Go to WAIT_LO the next cycle.
- WAIT_LO:
  - Hold the strobes.
  - Advance to WAIT_HI when ch2rdy=0.
  - If the LO_WAIT_MAX counter expires with ch2rdy=1, advance to WAIT_HI anyway.
- WAIT_HI:
  - Hold the strobes until ch2rdy=1.
  - On that cycle, capture ch2dout into the half's position of dout (reads only) and drop ch2rd/ch2wr.
- RELEASE:
  - Strobes low for RELEASE_CYCLES cycles, using a counter.
  - Then go to ISSUE for the remaining half, or DONE if none remains.
- DONE:
  - ack=1 for one cycle.
  - Read halves that were not issued leave their previous dout bits unchanged.
  - busy drops on the following cycle. The next req can be accepted in IDLE, at the earliest 1 cycle after ack.
- Fixed rules:
  - ch2rd and ch2wr are never both active.
  - ch2addr/ch2din are stable throughout ISSUE..WAIT_HI.
  - req while busy=1 is ignored. The client must hold or re-strobe it.
- Latency: a minimal single-half access is roughly 3 + controller slot wait + RELEASE_CYCLES cycles.

Test Plan:
- Read, addr=20'h00010, be=F, controller model returns 16'h1234 then 16'h5678 → two ch2 reads at ch2addr 21'h000020 and 21'h000021, each followed by ≥2 strobe-low cycles; ack once with dout=32'h12345678.
- Write, addr=20'h00003, din=32'hAABBCCDD, be=4'b0011 → single ch2 access: ch2addr=21'h000007, ch2din=16'hCCDD, ch2wr=2'b11; no HI access; ack once.
- Write with be=4'b1000 → single access: ch2addr even, ch2din=din[31:16], ch2wr=2'b10; low half untouched.
- Controller model holds ch2rdy=1 and never lowers it → WAIT_LO timeout after 8 cycles; transaction completes; ack asserted; no hang.
- rst_n pulled low during WAIT_HI of the HI half → same cycle: ch2rd=0, busy=0, ack=0, dout=0; after release, a new read completes with the correct data.
- Back-to-back: req held high across two reads → second accepted only after busy drops; strobe low gap ≥ RELEASE_CYCLES between every pair of ch2 accesses.
